// File: rtl/demux_stream.sv
// demux_stream: registered one-to-N valid/ready stream demultiplexer.
// Each input beat is steered by in_sel into a one-entry register per output
// channel. Beats whose select names a channel that does not exist are
// discarded and counted in a saturating 8-bit drop counter.
module demux_stream #(
  parameter int N_OUT = 4,
  parameter int W     = 8,
  parameter int SEL_W = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       in_data,
  input  logic [SEL_W-1:0]   in_sel,
  output logic [N_OUT-1:0]   out_valid,
  input  logic [N_OUT-1:0]   out_ready,
  output logic [N_OUT*W-1:0] out_data,
  output logic [7:0]         drop_cnt
);

  // One extra bit so N_OUT itself is representable when N_OUT is a power of two.
  localparam logic [SEL_W:0] N_OUT_L = (SEL_W+1)'(N_OUT);

  logic [N_OUT-1:0]   valid_r;
  logic [N_OUT*W-1:0] data_r;
  logic [7:0]         drop_cnt_r;
  logic               sel_legal_s;
  logic               in_ready_s;
  logic               in_xfer_s;

  // Select decode and pass-through ready: a full channel still accepts when its consumer drains now.
  always_comb begin
    sel_legal_s = 1'b0;
    in_ready_s  = 1'b0;
    in_xfer_s   = 1'b0;
    sel_legal_s = ({1'b0, in_sel} < N_OUT_L);
    if (!rst_n) begin
      // Legal destinations are closed during reset; illegal ones still read as sink-ready.
      in_ready_s = !sel_legal_s;
    end else if (sel_legal_s) begin
      in_ready_s = !valid_r[in_sel] || out_ready[in_sel];
    end else begin
      in_ready_s = 1'b1;
    end
    in_xfer_s = in_valid && in_ready_s;
  end

  // Per-channel holding registers: refill wins over drain so back-to-back beats have no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= {N_OUT{1'b0}};
      data_r  <= {(N_OUT*W){1'b0}};
    end else begin
      for (int i = 0; i < N_OUT; i++) begin
        if (in_xfer_s && sel_legal_s && (in_sel == SEL_W'(i))) begin
          data_r[i*W +: W] <= in_data;
          valid_r[i]       <= 1'b1;
        end else if (valid_r[i] && out_ready[i]) begin
          valid_r[i]       <= 1'b0;
        end else begin
          valid_r[i]       <= valid_r[i];
        end
      end
    end
  end

  // Drop counter for accepted beats with an out-of-range select, sticking at its maximum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_r <= 8'd0;
    end else if (in_xfer_s && !sel_legal_s && (drop_cnt_r != 8'hFF)) begin
      drop_cnt_r <= drop_cnt_r + 8'd1;
    end else begin
      drop_cnt_r <= drop_cnt_r;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = valid_r;
  assign out_data  = data_r;
  assign drop_cnt  = drop_cnt_r;

endmodule

// File: tb/tb_demux_stream.sv
// Bench for demux_stream: a 4-channel instance checked by vector table,
// directed sequences and a queue-per-channel reference model under random
// traffic, plus a 3-channel instance for illegal-select dropping.
module tb_demux_stream;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 4-channel instance
  logic        iv4 = 1'b0, rdy4;
  logic [1:0]  sel4 = 2'd0;
  logic [7:0]  d4 = 8'd0;
  logic [3:0]  ov4, or4 = 4'd0;
  logic [31:0] od4;
  logic [7:0]  dc4;

  // 3-channel instance
  logic        iv3 = 1'b0, rdy3;
  logic [1:0]  sel3 = 2'd0;
  logic [7:0]  d3 = 8'd0;
  logic [2:0]  ov3, or3 = 3'd0;
  logic [23:0] od3;
  logic [7:0]  dc3;

  demux_stream #(.N_OUT(4), .W(8)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(rdy4), .in_data(d4),
    .in_sel(sel4), .out_valid(ov4), .out_ready(or4), .out_data(od4), .drop_cnt(dc4));

  demux_stream #(.N_OUT(3), .W(8)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv3), .in_ready(rdy3), .in_data(d3),
    .in_sel(sel3), .out_valid(ov3), .out_ready(or3), .out_data(od3), .drop_cnt(dc3));

  int checks = 0;
  int failures = 0;

  // Reference: per channel, the beats accepted but not yet taken by the consumer.
  logic [7:0] mq [4][$];
  logic [3:0]  prev_ov = 4'd0, prev_r = 4'd0;
  logic [31:0] prev_od = 32'd0;

  typedef struct {
    logic        iv;
    logic [1:0]  sel;
    logic [7:0]  d;
    logic [3:0]  ordy;
    logic        exp_rdy;
    logic [3:0]  exp_ov;
    logic [31:0] exp_od;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mask_of(input logic [3:0] v);
    logic [31:0] m;
    m = 32'd0;
    for (int c = 0; c < 4; c++) if (v[c]) m[c*8 +: 8] = 8'hFF;
    return m;
  endfunction

  // One cycle on the 4-channel instance: drive, check against model (and optional explicit
  // expectations), then advance the model across the rising edge.
  task automatic step4(input logic v, input logic [1:0] s, input logic [7:0] d,
                       input logic [3:0] r, input bit has_exp, input logic e_rdy,
                       input logic [3:0] e_ov, input logic [31:0] e_od);
    logic [3:0] m_ov;
    logic       m_rdy;
    @(negedge clk);
    iv4 = v; sel4 = s; d4 = d; or4 = r;
    #1;
    for (int c = 0; c < 4; c++) m_ov[c] = (mq[c].size() > 0);
    m_rdy = (mq[s].size() == 0) || r[s];
    chk("model_out_valid", {28'd0, ov4}, {28'd0, m_ov});
    chk("model_in_ready", {31'd0, rdy4}, {31'd0, m_rdy});
    for (int c = 0; c < 4; c++) begin
      if (mq[c].size() > 0) chk("model_out_data", {24'd0, od4[c*8 +: 8]}, {24'd0, mq[c][0]});
      if (prev_ov[c] && !prev_r[c]) begin
        chk("stable_valid", {31'd0, ov4[c]}, 32'd1);
        chk("stable_data", {24'd0, od4[c*8 +: 8]}, {24'd0, prev_od[c*8 +: 8]});
      end
    end
    if (has_exp) begin
      chk("vec_in_ready", {31'd0, rdy4}, {31'd0, e_rdy});
      chk("vec_out_valid", {28'd0, ov4}, {28'd0, e_ov});
      chk("vec_out_data", od4 & mask_of(e_ov), e_od & mask_of(e_ov));
    end
    prev_ov = ov4; prev_od = od4; prev_r = r;
    @(posedge clk);
    for (int c = 0; c < 4; c++) if (mq[c].size() > 0 && r[c]) void'(mq[c].pop_front());
    if (v && m_rdy) mq[s].push_back(d);
  endtask

  // One cycle on the 3-channel instance with explicit expectations only.
  task automatic step3(input logic v, input logic [1:0] s, input logic [7:0] d,
                       input logic [2:0] r, input logic e_rdy, input logic [2:0] e_ov,
                       input logic [7:0] e_dc, input logic [7:0] e_d0);
    @(negedge clk);
    iv3 = v; sel3 = s; d3 = d; or3 = r;
    #1;
    chk("ill_in_ready", {31'd0, rdy3}, {31'd0, e_rdy});
    chk("ill_out_valid", {29'd0, ov3}, {29'd0, e_ov});
    chk("ill_drop_cnt", {24'd0, dc3}, {24'd0, e_dc});
    if (e_ov[0]) chk("ill_data0", {24'd0, od3[7:0]}, {24'd0, e_d0});
    @(posedge clk);
  endtask

  initial begin
    // Backpressure then simultaneous drain/refill, starting from empty channels.
    vecs[0]  = '{1'b1, 2'd0, 8'h10, 4'b1101, 1'b1, 4'b0000, 32'h0000_0000};
    vecs[1]  = '{1'b1, 2'd1, 8'h11, 4'b1100, 1'b1, 4'b0001, 32'h0000_0010};
    vecs[2]  = '{1'b1, 2'd1, 8'h22, 4'b1101, 1'b0, 4'b0011, 32'h0000_1110};
    vecs[3]  = '{1'b1, 2'd1, 8'h22, 4'b1111, 1'b1, 4'b0010, 32'h0000_1100};
    vecs[4]  = '{1'b1, 2'd0, 8'h33, 4'b1111, 1'b1, 4'b0010, 32'h0000_2200};
    vecs[5]  = '{1'b0, 2'd0, 8'h00, 4'b1111, 1'b1, 4'b0001, 32'h0000_0033};
    vecs[6]  = '{1'b1, 2'd3, 8'h7E, 4'b0111, 1'b1, 4'b0000, 32'h0000_0000};
    vecs[7]  = '{1'b1, 2'd3, 8'h7F, 4'b1111, 1'b1, 4'b1000, 32'h7E00_0000};
    vecs[8]  = '{1'b0, 2'd3, 8'h00, 4'b0111, 1'b0, 4'b1000, 32'h7F00_0000};
    vecs[9]  = '{1'b0, 2'd3, 8'h00, 4'b1111, 1'b1, 4'b1000, 32'h7F00_0000};
    vecs[10] = '{1'b0, 2'd0, 8'h00, 4'b1111, 1'b1, 4'b0000, 32'h0000_0000};

    // Power-on reset.
    repeat (3) @(negedge clk);
    chk("por_out_valid4", {28'd0, ov4}, 32'd0);
    chk("por_out_data4", od4, 32'd0);
    chk("por_drop_cnt3", {24'd0, dc3}, 32'd0);
    rst_n = 1'b1;

    // Illegal select on the 3-channel instance: dropped, counted, saturating.
    for (int k = 0; k < 300; k++)
      step3(1'b1, 2'd3, 8'($urandom), 3'b000, 1'b1, 3'b000, (k < 255) ? 8'(k) : 8'd255, 8'h00);
    step3(1'b1, 2'd0, 8'h55, 3'b000, 1'b1, 3'b000, 8'd255, 8'h00);
    step3(1'b0, 2'd0, 8'h00, 3'b000, 1'b0, 3'b001, 8'd255, 8'h55);
    step3(1'b0, 2'd0, 8'h00, 3'b001, 1'b1, 3'b001, 8'd255, 8'h55);
    step3(1'b0, 2'd0, 8'h00, 3'b000, 1'b1, 3'b000, 8'd255, 8'h00);

    // Streaming: every beat one cycle later on channel k % 4, ready never drops.
    for (int k = 0; k <= 16; k++) begin
      logic [31:0] e_od;
      logic [3:0]  e_ov;
      e_ov = 4'd0;
      e_od = 32'd0;
      if (k > 0) begin
        e_ov[(k-1) % 4] = 1'b1;
        e_od[((k-1) % 4)*8 +: 8] = 8'(k-1);
      end
      step4(k < 16, 2'(k % 4), 8'(k), 4'hF, 1'b1, 1'b1, e_ov, e_od);
    end

    // Table-driven backpressure and drain/refill vectors.
    for (int i = 0; i < 11; i++)
      step4(vecs[i].iv, vecs[i].sel, vecs[i].d, vecs[i].ordy, 1'b1,
            vecs[i].exp_rdy, vecs[i].exp_ov, vecs[i].exp_od);

    // Reset mid-stream with channel 2 holding 0xA5: outputs clear without a clock edge.
    step4(1'b1, 2'd2, 8'hA5, 4'b1011, 1'b1, 1'b1, 4'b0000, 32'h0);
    step4(1'b0, 2'd1, 8'h00, 4'b1011, 1'b1, 1'b1, 4'b0100, 32'h00A5_0000);
    @(negedge clk);
    iv4 = 1'b0; sel4 = 2'd1; or4 = 4'b0000;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid4", {28'd0, ov4}, 32'd0);
    chk("rst_out_data4", od4, 32'd0);
    chk("rst_drop_cnt3", {24'd0, dc3}, 32'd0);
    chk("rst_in_ready_legal", {31'd0, rdy4}, 32'd0);
    for (int c = 0; c < 4; c++) mq[c].delete();
    prev_ov = 4'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step4(1'b1, 2'd1, 8'h3C, 4'b1111, 1'b1, 1'b1, 4'b0000, 32'h0);
    step4(1'b0, 2'd0, 8'h00, 4'b1111, 1'b1, 1'b1, 4'b0010, 32'h0000_3C00);

    // Random traffic against the queue model.
    for (int n = 0; n < 2000; n++) begin
      logic [3:0] r;
      for (int c = 0; c < 4; c++) r[c] = ($urandom_range(0, 3) != 0);
      step4(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom), r,
            1'b0, 1'b0, 4'd0, 32'd0);
    end
    for (int n = 0; n < 3; n++) step4(1'b0, 2'd0, 8'h00, 4'hF, 1'b0, 1'b0, 4'd0, 32'd0);
    chk("final_empty", {28'd0, ov4}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demux_stream.md
# demux_stream

Registered one-to-N stream demultiplexer: accepts one valid/ready input stream tagged with a select value and routes each beat to one of N_OUT output channels. Each output channel holds one beat in its own register. It is the distributing counterpart of the 2:1 `mux` primitive, for places where one producer feeds several independent consumers. Beats with an out-of-range select are dropped and counted.

## Interface
- N_OUT, 4: number of output channels (2..16).
- W, 8: data width in bits.
- SEL_W, $clog2(N_OUT) (min 1): select width. `in_sel` values ≥ N_OUT are illegal.
- clk  input  1  sole clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset. Assertion clears state immediately. Release is synchronous to `clk`.
- in_valid  input  1  input beat present.
- in_ready  output  1  block accepts the input beat this cycle.
- in_data  input  W  input payload.
- in_sel  input  SEL_W  destination channel index.
- out_valid  output  N_OUT  bit i: channel i holds a beat.
- out_ready  input  N_OUT  bit i: consumer i takes the beat this cycle.
- out_data  output  N_OUT*W  channel i payload in bits [i*W +: W].
- drop_cnt  output  8  saturating count of beats dropped for an illegal select.

## Operation
- Handshakes:
  - Input transfer: `in_valid && in_ready`.
  - Output i transfer: `out_valid[i] && out_ready[i]`.
- Per channel i, a one-entry register holds `data_q[i]` and `valid_q[i]`. `out_valid[i] = valid_q[i]` and `out_data` slice i = `data_q[i]`.
- `in_ready` is combinational:
  - Legal `in_sel`: `in_ready = !valid_q[in_sel] || out_ready[in_sel]`. This pass-through ready allows back-to-back beats.
  - Illegal `in_sel`: `in_ready = 1`.
  - `in_ready` depends only on `in_sel`, `valid_q` and `out_ready`, never on `in_valid`.
- Channel i update on each clock edge:
  - Input transfer with `in_sel == i`: `data_q[i] <= in_data` and `valid_q[i] <= 1`. This applies even if channel i transfers out in the same cycle (simultaneous drain and refill).
  - Otherwise, output i transfer: `valid_q[i] <= 0`. `data_q[i]` is held, but its value is don't-care.
  - Otherwise: both hold.
- Channels are independent. A stalled channel blocks only input beats addressed to it, which by ordering blocks the whole input (head-of-line). Other channels keep draining.
- Illegal select on an input transfer:
  - Beat is discarded. No `valid_q` bit changes.
  - `drop_cnt` increments, saturating at 255.
- Ordering: beats to the same channel leave in input order. There is no ordering relation between channels.
- Reset: `valid_q` = 0, `data_q` = 0, `drop_cnt` = 0. `out_valid` and `out_data` read 0 while `rst_n` is low. A beat held in a channel at reset assertion is lost.

## Timing
- Latency: 1 cycle. A beat accepted at edge k shows `out_valid[sel]` = 1 after edge k.
- Throughput: 1 beat/cycle into any single channel while its `out_ready` is held high.
- `out_valid[i]`, once high, stays high with stable `out_data` slice i until the consumer transfers. This is AXI-stream-style stability.
- `in_ready` during reset: 0 for a legal `in_sel`, 1 for an illegal one. Both are don't-care for the producer, which must not drive `in_valid` during reset.
- Combinational paths: `out_ready` and `in_sel` → `in_ready` only. No path from `in_valid` or `in_data` to any output.

## Test plan
- **Reset:** assert `rst_n` = 0 mid-stream with channel 2 holding 0xA5 → all `out_valid` = 0, `out_data` = 0 and `drop_cnt` = 0 immediately (no clock needed). After release, the first beat (sel = 1, 0x3C) appears on channel 1 one cycle later.
- **Streaming:** all `out_ready` = 1; send 0x00..0x0F with sel = i % 4 back-to-back → `in_ready` stays 1, every beat appears exactly 1 cycle later on channel i % 4, no gaps.
- **Backpressure:** `out_ready[1]` = 0. Send 0x11 (sel 1), then 0x22 (sel 1), then 0x33 (sel 0):
  - 0x11 is accepted.
  - `in_ready` = 0 while 0x22 is presented. Channel 0 keeps draining its prior beat.
  - Raise `out_ready[1]`: 0x11 leaves and 0x22 is accepted in the same cycle, then 0x33 follows.
- **Simultaneous drain/refill:** channel 3 holds 0x7E with `out_ready[3]` = 1 while 0x7F (sel 3) arrives → `out_valid[3]` stays 1, data becomes 0x7F next cycle, no bubble, no loss.
- **Illegal select (N_OUT = 3, SEL_W = 2):**
  - 300 beats with sel = 3 → `in_ready` = 1 throughout, no `out_valid` rises, `drop_cnt` saturates at 255.
  - Then a legal beat (sel = 0, 0x55) arrives normally.
- **Random:** constrained-random `in_valid` / `in_sel` / `out_ready` with a scoreboard of one queue per channel → no loss, duplication or reordering per channel. Stability holds on every stalled cycle.
